// File: rtl/psum_drain_collector.sv
// Bottom-edge partial-sum collector: deskews per-column outputs into row vectors and queues them.
// Optional macro PSUM_DRAIN_RELU_EN clamps negative elements to zero on FIFO write.
module psum_drain_collector #(
    parameter int BW_ACCU    = 32,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BW_CNT     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    drain_start,
    input  logic [BW_CNT-1:0]       drain_vec_count,
    input  logic [COLS*BW_ACCU-1:0] col_psum_in,
    input  logic [COLS-1:0]         col_sel_in,
    input  logic [COLS-1:0]         col_valid_in,
    output logic [COLS*BW_ACCU-1:0] vec_out,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    drain_busy,
    output logic                    drain_done,
    output logic                    ovf_err,
    output logic                    skew_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

    state_t                    state_reg, state_next;
    logic [COLS-1:0]           qual_valid;
    logic [COLS-1:0]           aligned_valid;
    logic [COLS*BW_ACCU-1:0]   aligned_data;
    logic [COLS*BW_ACCU-1:0]   wr_data;
    logic [COLS*BW_ACCU-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr_reg, rd_ptr_reg;
    logic [BW_CNT-1:0]         cnt_reg, count_reg;
    logic                      ovf_reg, skew_reg;
    logic                      push, pop, wr_en, drop, skew_mismatch;
    logic                      fifo_empty, fifo_full, start_ok;

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            localparam int DLY = COLS - 1 - gi;
            // Weight traffic on the partial-sum bus is never a sample.
            assign qual_valid[gi] = col_valid_in[gi] & ~col_sel_in[gi];

            if (DLY == 0) begin : g_pass
                assign aligned_valid[gi]                  = qual_valid[gi];
                assign aligned_data[gi*BW_ACCU +: BW_ACCU] = col_psum_in[gi*BW_ACCU +: BW_ACCU];
            end else begin : g_dly
                logic [DLY-1:0]     v_pipe;
                logic [BW_ACCU-1:0] d_pipe [DLY];
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        v_pipe <= '0;
                        for (int i = 0; i < DLY; i++) d_pipe[i] <= '0;
                    end else begin
                        v_pipe[0] <= qual_valid[gi];
                        d_pipe[0] <= col_psum_in[gi*BW_ACCU +: BW_ACCU];
                        for (int i = 1; i < DLY; i++) begin
                            v_pipe[i] <= v_pipe[i-1];
                            d_pipe[i] <= d_pipe[i-1];
                        end
                    end
                end
                assign aligned_valid[gi]                  = v_pipe[DLY-1];
                assign aligned_data[gi*BW_ACCU +: BW_ACCU] = d_pipe[DLY-1];
            end

`ifdef PSUM_DRAIN_RELU_EN
            assign wr_data[gi*BW_ACCU +: BW_ACCU] = aligned_data[gi*BW_ACCU + BW_ACCU - 1] ?
                                                    '0 : aligned_data[gi*BW_ACCU +: BW_ACCU];
`else
            assign wr_data[gi*BW_ACCU +: BW_ACCU] = aligned_data[gi*BW_ACCU +: BW_ACCU];
`endif
        end
    endgenerate

    assign start_ok   = (state_reg == IDLE) && drain_start;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push       = (state_reg == COLLECT) && aligned_valid[COLS-1];
    // During a push the last column is 1, so any zero elsewhere is a skew fault.
    assign skew_mismatch = (aligned_valid != {COLS{1'b1}});
    assign pop        = !fifo_empty && vec_ready;
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    assign vec_out    = mem[rd_ptr_reg[AW-1:0]];
    assign vec_valid  = !fifo_empty;
    assign drain_busy = (state_reg != IDLE);
    assign ovf_err    = ovf_reg;
    assign skew_err   = skew_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_reg[AW-1:0]] <= wr_data;
                wr_ptr_reg              <= wr_ptr_reg + 1'b1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            skew_reg  <= 1'b0;
        end else if (start_ok) begin
            cnt_reg   <= '0;
            count_reg <= drain_vec_count;
            ovf_reg   <= 1'b0;
            skew_reg  <= 1'b0;
        end else begin
            // Dropped pushes still count: the array produced the vector regardless.
            if (push && (cnt_reg != count_reg)) cnt_reg <= cnt_reg + BW_CNT'(1);
            if (drop) ovf_reg <= 1'b1;
            if (push && skew_mismatch) skew_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        drain_done = 1'b0;
        case (state_reg)
            IDLE:    if (drain_start) state_next = COLLECT;
            COLLECT: if (cnt_reg == count_reg) state_next = FLUSH;
            FLUSH: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector (COLS=4, BW_ACCU=32, FIFO_DEPTH=4).
module tb_psum_drain_collector;

    localparam int COLS = 4;
    localparam int BW   = 32;
    localparam int DEP  = 4;
    localparam int BWC  = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 drain_start = 1'b0;
    logic [BWC-1:0]       drain_vec_count = '0;
    logic [COLS*BW-1:0]   col_psum_in = '0;
    logic [COLS-1:0]      col_sel_in = '0;
    logic [COLS-1:0]      col_valid_in = '0;
    logic [COLS*BW-1:0]   vec_out;
    logic                 vec_valid;
    logic                 vec_ready = 1'b0;
    logic                 drain_busy;
    logic                 drain_done;
    logic                 ovf_err;
    logic                 skew_err;

    int n_cmp = 0;
    int n_err = 0;

    psum_drain_collector #(
        .BW_ACCU(BW), .COLS(COLS), .FIFO_DEPTH(DEP), .BW_CNT(BWC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .drain_start(drain_start), .drain_vec_count(drain_vec_count),
        .col_psum_in(col_psum_in), .col_sel_in(col_sel_in), .col_valid_in(col_valid_in),
        .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .drain_busy(drain_busy), .drain_done(drain_done),
        .ovf_err(ovf_err), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [127:0] exp_vec(input int base, input int j);
        logic [127:0] r;
        for (int c = 0; c < COLS; c++) r[c*BW +: BW] = BW'(base + 10*j + c);
        return r;
    endfunction

    task automatic clear_in();
        col_valid_in = '0;
        col_sel_in   = '0;
        col_psum_in  = '0;
    endtask

    // Skewed stream: column c carries vector j in cycle k = j + c.
    task automatic drive_cycle(input int k, input int n, input int base);
        clear_in();
        for (int c = 0; c < COLS; c++) begin
            if ((k - c) >= 0 && (k - c) < n) begin
                col_valid_in[c]         = 1'b1;
                col_psum_in[c*BW +: BW] = BW'(base + 10*(k - c) + c);
            end
        end
    endtask

    task automatic start(input int cnt);
        drain_vec_count = BWC'(cnt);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (drain_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, 128'(seen), 128'd1);
        step();
    endtask

    logic [BW-1:0] relu_vals [COLS];

    initial begin
        step(); step();
        check("rst_vec_out", vec_out, 128'd0);
        check("rst_flags", {vec_valid, drain_busy, drain_done, ovf_err, skew_err}, 128'd0);
        reset_n = 1'b1;
        step();

        // Aligned drain, two vectors, ready high
        vec_ready = 1'b1;
        start(2);
        check("busy_after_start", 128'(drain_busy), 128'd1);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) check("aligned_v0", vec_out, exp_vec(10, 0));
            if (k == 5) check("aligned_v1", vec_out, exp_vec(10, 1));
            drive_cycle(k, 2, 10);
            step();
        end
        clear_in();
        wait_done("aligned_done");
        check("aligned_errs", {ovf_err, skew_err}, 128'd0);
        check("aligned_idle", 128'(drain_busy), 128'd0);

        // Weight traffic never pushes; a start while busy is ignored
        start(1);
        for (int k = 0; k < 3; k++) begin
            col_sel_in = 4'hF; col_valid_in = 4'hF; col_psum_in = {4{32'd99}};
            step();
        end
        clear_in();
        drain_vec_count = '0;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("weight_no_push", 128'(vec_valid), 128'd0);
            step();
        end
        check("weight_still_collect", 128'(drain_busy), 128'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check("weight_then_vec", vec_out, exp_vec(50, 0));
            drive_cycle(k, 1, 50);
            step();
        end
        clear_in();
        wait_done("weight_done");

        // Overflow: five vectors into a four-deep FIFO with no ready
        vec_ready = 1'b0;
        start(5);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(k, 5, 100);
            step();
        end
        clear_in();
        step();
        check("ovf_flag", 128'(ovf_err), 128'd1);
        check("ovf_valid", 128'(vec_valid), 128'd1);
        vec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_pop%0d", i), vec_out, exp_vec(100, i));
            step();
        end
        check("ovf_empty", 128'(vec_valid), 128'd0);
        wait_done("ovf_done");

        // Full FIFO with simultaneous pop: nothing dropped
        vec_ready = 1'b0;
        start(5);
        check("ovf_cleared", 128'(ovf_err), 128'd0);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(k, 5, 300);
            if (k == 7) vec_ready = 1'b1;
            step();
        end
        clear_in();
        check("fullpop_no_ovf", 128'(ovf_err), 128'd0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("fullpop_v%0d", i), vec_out, exp_vec(300, i));
            step();
        end
        check("fullpop_empty", 128'(vec_valid), 128'd0);
        wait_done("fullpop_done");

        // Skew fault: column 0 arrives one cycle early
        vec_ready = 1'b0;
        start(1);
        clear_in();
        col_valid_in[0] = 1'b1;
        col_psum_in[BW-1:0] = 32'd200;
        step();
        for (int k = 0; k < 4; k++) begin
            drive_cycle(k, 1, 200);
            if (k == 0) col_valid_in[0] = 1'b0;
            step();
        end
        clear_in();
        check("skew_flag", 128'(skew_err), 128'd1);
        check("skew_pushed", 128'(vec_valid), 128'd1);
        vec_ready = 1'b1;
        wait_done("skew_done");
        start(0);
        check("skew_cleared", 128'(skew_err), 128'd0);
        wait_done("zero_count_done");

        // ReLU path and reset during FLUSH
        vec_ready = 1'b0;
        relu_vals[0] = 32'hFFFF_FFF6;
        relu_vals[1] = 32'd7;
        relu_vals[2] = 32'd2;
        relu_vals[3] = 32'd3;
        start(1);
        for (int k = 0; k < 4; k++) begin
            clear_in();
            col_valid_in[k] = 1'b1;
            col_psum_in[k*BW +: BW] = relu_vals[k];
            step();
        end
        clear_in();
        step(); step();
        check("flush_busy", {drain_busy, vec_valid}, 128'd3);
`ifdef PSUM_DRAIN_RELU_EN
        check("relu_neg", 128'(vec_out[31:0]), 128'd0);
`else
        check("relu_neg", 128'(vec_out[31:0]), 128'hFFFF_FFF6);
`endif
        check("relu_pos", 128'(vec_out[63:32]), 128'd7);
        reset_n = 1'b0;
        #1;
        check("midrst_vec_out", vec_out, 128'd0);
        check("midrst_flags", {vec_valid, drain_busy, drain_done, ovf_err, skew_err}, 128'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_idle", {vec_valid, drain_busy}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
